// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame builder.
// ADC_FRAME_CHKSUM_EN adds the XOR trailer state.
package adc_frame_pkg;

  localparam logic [15:0]  ADC_HDR_MAGIC = 16'hA5C0;
  localparam int unsigned  ADC_SEQ_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHeader  = 2'd1,
    StPayload = 2'd2
`ifdef ADC_FRAME_CHKSUM_EN
    ,
    StTrailer = 2'd3
`endif
  } adc_frame_state_t;

endpackage

// File: rtl/adc_skid_buf.sv
// Two-entry valid/ready buffer that absorbs the FIFO read latency.
// Entry 0 is always the head; count reports current occupancy.
module adc_skid_buf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pop, push_ok;

  assign out_valid = (cnt_q != 2'd0);
  assign dout      = ent0_q;
  assign count     = cnt_q;
  assign pop       = out_valid && out_ready;
  // A push into a full buffer is only taken when the head leaves the same cycle.
  assign push_ok   = push && ((cnt_q != 2'd2) || pop);

  // Next-state: append at tail, shift on pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = din;
        else               ent1_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = din;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_frame_builder.sv
// Drains ADC sample words from the read side of the sample FIFO and frames them:
// header {A5C0, seq}, FRAME_WORDS payload words, and with ADC_FRAME_CHKSUM_EN an
// XOR trailer. Output is a valid/ready stream with m_last on the final word.
module adc_frame_builder import adc_frame_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FRAME_WORDS = 64
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     enable,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic                     fifo_valid,
  input  logic [DATA_WIDTH-1:0]    fifo_dout,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [ADC_SEQ_WIDTH-1:0] frame_cnt,
  output logic                     busy
);

  localparam int unsigned     CntW     = $clog2(FRAME_WORDS + 1);
  localparam logic [CntW-1:0] NumWords = CntW'(FRAME_WORDS);
  localparam logic [CntW-1:0] LastIdx  = CntW'(FRAME_WORDS - 1);

  adc_frame_state_t         state_q, state_d;
  logic [CntW-1:0]          req_cnt_q, req_cnt_d;
  logic [CntW-1:0]          out_cnt_q, out_cnt_d;
  logic [ADC_SEQ_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                     inflight_q;
`ifdef ADC_FRAME_CHKSUM_EN
  logic [DATA_WIDTH-1:0]    chk_q, chk_d;
`endif

  logic [1:0]            skid_count;
  logic [DATA_WIDTH-1:0] skid_dout;
  logic                  skid_valid, skid_ready, skid_pop, skid_push;
  logic [2:0]            occ;
  logic                  rd_ok;

  // Read data is only trusted when a read is actually outstanding.
  assign skid_push  = fifo_valid && inflight_q;
  assign skid_ready = (state_q == StPayload) && m_ready;
  assign skid_pop   = skid_valid && skid_ready;
  // Occupancy after this cycle's hand-off, so reads keep pace at one word per cycle.
  assign occ        = {1'b0, skid_count} - {2'b00, skid_pop} + {2'b00, inflight_q};
  assign rd_ok      = !fifo_empty && (occ < 3'd2) && (req_cnt_q < NumWords);

  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != StIdle);

  adc_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .push      (skid_push),
    .din       (fifo_dout),
    .count     (skid_count),
    .dout      (skid_dout),
    .out_valid (skid_valid),
    .out_ready (skid_ready)
  );

  // Next-state and stream outputs. Reads may start in HEADER to hide FIFO latency.
  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
`ifdef ADC_FRAME_CHKSUM_EN
    chk_d       = chk_q;
`endif
    fifo_rd_en  = 1'b0;
    m_data      = '0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && !fifo_empty) begin
          state_d   = StHeader;
          req_cnt_d = '0;
          out_cnt_d = '0;
`ifdef ADC_FRAME_CHKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      StHeader: begin
        m_data     = DATA_WIDTH'({ADC_HDR_MAGIC, frame_cnt_q});
        m_valid    = 1'b1;
        fifo_rd_en = rd_ok;
        if (m_ready) state_d = StPayload;
      end
      StPayload: begin
        m_data     = skid_dout;
        m_valid    = skid_valid;
        fifo_rd_en = rd_ok;
`ifndef ADC_FRAME_CHKSUM_EN
        m_last     = skid_valid && (out_cnt_q == LastIdx);
`endif
        if (skid_pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
`ifdef ADC_FRAME_CHKSUM_EN
          chk_d     = chk_q ^ skid_dout;
`endif
          if (out_cnt_q == LastIdx) begin
`ifdef ADC_FRAME_CHKSUM_EN
            state_d     = StTrailer;
`else
            state_d     = StIdle;
            frame_cnt_d = frame_cnt_q + 1'b1;
`endif
          end
        end
      end
`ifdef ADC_FRAME_CHKSUM_EN
      StTrailer: begin
        m_data  = chk_q;
        m_valid = 1'b1;
        m_last  = 1'b1;
        if (m_ready) begin
          state_d     = StIdle;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    if (fifo_rd_en) req_cnt_d = req_cnt_q + 1'b1;
  end

  // State, counters and outstanding-read flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      req_cnt_q   <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= '0;
      inflight_q  <= 1'b0;
`ifdef ADC_FRAME_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      inflight_q  <= fifo_rd_en;
`ifdef ADC_FRAME_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_frame_builder.sv
// Scoreboard bench for adc_frame_builder with FRAME_WORDS=4. A FIFO model answers
// reads one cycle later; a monitor pops expected words on every stream handshake.
module tb_adc_frame_builder;

  localparam int unsigned FW = 4;
`ifdef ADC_FRAME_CHKSUM_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        fifo_valid = 1'b0;
  logic [31:0] fifo_dout = 32'h0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [15:0] frame_cnt;
  logic        busy;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          rd_count = 0;
  bit          toggle_ready = 1'b0;
  bit          stray_req = 1'b0;
  bit          rd_pending = 1'b0;
  logic [31:0] rd_word = 32'h0;
  logic [15:0] seq = 16'h0;

  always #5 sys_clk = ~sys_clk;

  adc_frame_builder #(
    .DATA_WIDTH  (32),
    .FRAME_WORDS (FW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_valid (fifo_valid),
    .fifo_dout  (fifo_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Header, payload base+i, and the XOR trailer when built with the checksum.
  task automatic expect_frame(input logic [15:0] s, input logic [31:0] base, input bit load);
    logic [31:0] x;
    logic [31:0] w;
    x = 32'h0;
    exp_q.push_back('{data: {16'hA5C0, s}, last: 1'b0});
    for (int i = 0; i < FW; i++) begin
      w = base + i;
      x = x ^ w;
      if (load) fq.push_back(w);
      exp_q.push_back('{data: w, last: (!Chk && (i == FW - 1))});
    end
    if (Chk) exp_q.push_back('{data: x, last: 1'b1});
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      #3;
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_done"}, (i < limit), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // FIFO read side: data valid the cycle after an accepted read.
  initial begin
    forever begin
      @(negedge sys_clk);
      fifo_valid = rd_pending || stray_req;
      fifo_dout  = rd_pending ? rd_word : 32'hDEAD_BEEF;
      rd_pending = 1'b0;
      stray_req  = 1'b0;
      m_ready    = toggle_ready ? ~m_ready : 1'b1;
      fifo_empty = (fq.size() == 0);
      #1;
      if (fifo_rd_en) begin
        check("rd_en_while_empty", fifo_empty, 0);
        if (!fifo_empty) begin
          rd_word    = fq.pop_front();
          rd_pending = 1'b1;
          rd_count++;
        end
      end
    end
  end

  // Stream monitor: scoreboard pop on handshake, hold check while stalled.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    prev_last  = 1'b0;
    forever begin
      @(negedge sys_clk);
      #2;
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, none expected", m_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", m_data, e.data);
          check("stream_last", m_last, e.last);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    int base;
    int i;
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge sys_clk);
    #3;
    check_reset_outputs("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Single frame 1..4, m_ready high, cycle-accurate latency checks
    expect_frame(seq, 32'h1, 1'b1);
    base = rd_count;
    @(negedge sys_clk);
    enable = 1'b1;
    @(negedge sys_clk);
    #3;
    check("hdr_busy", busy, 1);
    check("hdr_valid", m_valid, 1);
    check("hdr_data", m_data, 32'hA5C0_0000);
    @(negedge sys_clk);
    #3;
    check("payload_gap_valid", m_valid, 0);
    for (int k = 1; k <= FW; k++) begin
      @(negedge sys_clk);
      #3;
      check("stream_rate_valid", m_valid, 1);
      check("stream_rate_data", m_data, k);
    end
    wait_done("single", 50);
    seq = seq + 1'b1;
    check("single_frame_cnt", frame_cnt, 1);
    check("single_reads", rd_count - base, FW);

    // Three frames with m_ready toggling every cycle
    base = rd_count;
    toggle_ready = 1'b1;
    for (int f = 0; f < 3; f++) expect_frame(seq + f[15:0], 32'h100 * (f + 1), 1'b1);
    seq = seq + 16'd3;
    wait_done("toggle", 300);
    toggle_ready = 1'b0;
    check("toggle_frame_cnt", frame_cnt, seq);
    check("toggle_reads", rd_count - base, 3 * FW);

    // FIFO runs dry after two payload words
    expect_frame(seq, 32'h5000, 1'b0);
    fq.push_back(32'h5000);
    fq.push_back(32'h5001);
    base = rd_count;
    for (i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      #3;
      if (rd_count == base + 2) break;
    end
    check("gap_two_reads", (i < 30), 1);
    for (int g = 0; g < 10; g++) begin
      @(negedge sys_clk);
      #3;
      if (g >= 3) begin
        check("gap_m_valid", m_valid, 0);
        check("gap_rd_en", fifo_rd_en, 0);
      end
    end
    fq.push_back(32'h5002);
    fq.push_back(32'h5003);
    wait_done("gap", 60);
    seq = seq + 1'b1;
    check("gap_frame_cnt", frame_cnt, seq);

    // Reset at the third payload word, stray fifo_valid right after
    exp_q.push_back('{data: {16'hA5C0, seq}, last: 1'b0});
    for (int k = 0; k < 3; k++) exp_q.push_back('{data: 32'h7000 + k, last: 1'b0});
    for (int k = 0; k < FW; k++) fq.push_back(32'h7000 + k);
    for (i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      #3;
      if (m_valid && m_ready && m_data == 32'h7002) break;
    end
    check("abort_reached_word3", (i < 40), 1);
    sys_rst   = 1'b1;
    stray_req = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #3;
    check_reset_outputs("abort");
    check("abort_scoreboard_empty", exp_q.size(), 0);
    seq = 16'h0;
    expect_frame(seq, 32'h8000, 1'b1);
    wait_done("after_abort", 60);
    seq = seq + 1'b1;
    check("after_abort_frame_cnt", frame_cnt, seq);

    // Sequence number wrap
    @(negedge sys_clk);
    force dut.frame_cnt_q = 16'hFFFF;
    repeat (2) @(negedge sys_clk);
    release dut.frame_cnt_q;
    #3;
    check("wrap_preload", frame_cnt, 16'hFFFF);
    expect_frame(16'hFFFF, 32'h9000, 1'b1);
    expect_frame(16'h0000, 32'hA000, 1'b1);
    wait_done("wrap", 80);
    check("wrap_frame_cnt", frame_cnt, 1);

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
